// File: rtl/tetris_input_sched.sv
// Button/gravity command scheduler feeding the tetris engine: edge detect, auto-repeat,
// fixed-priority arbitration and a one-cycle command pulse issued only while the engine waits.
package tetris_pkg;
  typedef enum logic [3:0] {
    NONE, INIT, GEN, WAIT, LEFT, RIGHT, ROTATE, ROTATE_REV,
    DOWN, DROP, HOLD, CLEAR, DCHECK, END
  } state_type;
endpackage

module tetris_input_sched
  import tetris_pkg::*;
#(
  parameter int unsigned GRAV_BASE = 50_000_000,
  parameter int unsigned GRAV_STEP = 4_500_000,
  parameter int unsigned DAS       = 10_000_000,
  parameter int unsigned ARR       = 3_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rot,
  input  logic        btn_rot_rev,
  input  logic        btn_down,
  input  logic        btn_drop,
  input  logic        btn_hold,
  input  state_type   state,
  input  logic [15:0] score,
  output state_type   ctrl,
  output logic [3:0]  level
);

  typedef enum logic {ARMED, ISSUE} fsm_type;

  // Bit order doubles as priority order: bit 0 (HOLD) is served first.
  localparam int unsigned P_HOLD    = 0;
  localparam int unsigned P_DROP    = 1;
  localparam int unsigned P_ROT     = 2;
  localparam int unsigned P_ROT_REV = 3;
  localparam int unsigned P_LEFT    = 4;
  localparam int unsigned P_RIGHT   = 5;
  localparam int unsigned P_DOWN    = 6;
  localparam logic [31:0] DAS_RELOAD = 32'(DAS - ARR);

  logic [6:0]  btn_vec;
  logic [6:0]  prev_reg;
  logic [6:0]  press_edge;
  logic [2:0]  rpt_fire;
  logic [6:0]  set_vec;
  logic [6:0]  pend_reg;
  logic        grav_pend_reg;
  logic [31:0] grav_cnt_reg;
  logic [31:0] grav_inc;
  logic [31:0] grav_period;
  logic        grav_hit;
  logic [3:0]  level_reg;
  logic [3:0]  level_next;
  state_type   state_prev_reg;
  state_type   ctrl_reg;
  state_type   cmd_next;
  fsm_type     fsm_reg;
  logic        issue;
  logic        token;
  logic        down_issue;
  logic        in_idle;
  logic        gen_entry;
  logic [6:0]  grant_vec;
  logic        grant_grav;
  logic        unused_score_lo;

  assign btn_vec = {btn_down, btn_right, btn_left, btn_rot_rev, btn_rot, btn_drop, btn_hold};
  assign press_edge = btn_vec & ~prev_reg;
  assign set_vec = press_edge | {rpt_fire, 4'b0000};
  assign unused_score_lo = ^score[3:0];

  // Hold counters run only after a real press edge, so a button held through reset stays silent.
  // The reload value assumes DAS > ARR.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rpt
      logic [31:0] hold_cnt_reg;
      logic [31:0] hold_inc;
      logic        hold_run;
      assign hold_inc = hold_cnt_reg + 32'd1;
      assign hold_run = btn_vec[P_LEFT + gi] && (hold_cnt_reg != 32'd0 || press_edge[P_LEFT + gi]);
      assign rpt_fire[gi] = hold_run && (hold_inc == DAS);
      always_ff @(posedge clk) begin
        if (reset || !btn_vec[P_LEFT + gi]) begin
          hold_cnt_reg <= '0;
        end else if (hold_run) begin
          hold_cnt_reg <= rpt_fire[gi] ? DAS_RELOAD : hold_inc;
        end
      end
    end
  endgenerate

  assign level_next  = (score[15:8] != 8'h00) ? 4'd9 : score[7:4];
  assign grav_period = 32'(GRAV_BASE) - 32'(level_reg) * 32'(GRAV_STEP);
  assign in_idle     = (state == INIT) || (state == GEN) || (state == END);
  assign gen_entry   = (state == GEN) && (state_prev_reg != GEN);
  assign grav_inc    = grav_cnt_reg + 32'd1;
  assign grav_hit    = !in_idle && !down_issue && (grav_inc >= grav_period - 32'd1);
  assign down_issue  = issue && (cmd_next == DOWN);

  always_comb begin
    issue      = 1'b0;
    token      = 1'b0;
    grant_vec  = '0;
    grant_grav = 1'b0;
    cmd_next   = NONE;
    if (fsm_reg == ARMED) begin
      if ((state == INIT || state == END) && (|press_edge)) begin
        token    = 1'b1;
        issue    = 1'b1;
        cmd_next = DOWN;
      end else if (state == WAIT && ((|pend_reg) || grav_pend_reg)) begin
        issue = 1'b1;
        if (pend_reg[P_HOLD]) begin
          grant_vec[P_HOLD] = 1'b1;
          cmd_next = HOLD;
        end else if (pend_reg[P_DROP]) begin
          grant_vec[P_DROP] = 1'b1;
          cmd_next = DROP;
        end else if (pend_reg[P_ROT]) begin
          grant_vec[P_ROT] = 1'b1;
          cmd_next = ROTATE;
        end else if (pend_reg[P_ROT_REV]) begin
          grant_vec[P_ROT_REV] = 1'b1;
          cmd_next = ROTATE_REV;
        end else if (pend_reg[P_LEFT]) begin
          grant_vec[P_LEFT] = 1'b1;
          cmd_next = LEFT;
        end else if (pend_reg[P_RIGHT]) begin
          grant_vec[P_RIGHT] = 1'b1;
          cmd_next = RIGHT;
        end else if (pend_reg[P_DOWN]) begin
          grant_vec[P_DOWN] = 1'b1;
          cmd_next = DOWN;
        end else begin
          grant_grav = 1'b1;
          cmd_next = DOWN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg  <= ARMED;
      ctrl_reg <= NONE;
    end else begin
      case (fsm_reg)
        ARMED: begin
          ctrl_reg <= issue ? cmd_next : NONE;
          if (issue) fsm_reg <= ISSUE;
        end
        default: begin
          ctrl_reg <= NONE;
          fsm_reg  <= ARMED;
        end
      endcase
    end
  end

  // Any DOWN, button or gravity, retires both DOWN sources; a fresh set in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg       <= '1;
      pend_reg       <= '0;
      grav_pend_reg  <= 1'b0;
      grav_cnt_reg   <= '0;
      level_reg      <= '0;
      state_prev_reg <= NONE;
    end else begin
      prev_reg       <= btn_vec;
      level_reg      <= level_next;
      state_prev_reg <= state;
      if (token || gen_entry) begin
        pend_reg <= '0;
      end else begin
        pend_reg <= (pend_reg & ~(grant_vec | {grant_grav, 6'b000000})) | set_vec;
      end
      if (token) begin
        grav_pend_reg <= 1'b0;
      end else if (grav_hit) begin
        grav_pend_reg <= 1'b1;
      end else if (grant_grav || grant_vec[P_DOWN]) begin
        grav_pend_reg <= 1'b0;
      end
      if (in_idle || down_issue || grav_hit) begin
        grav_cnt_reg <= '0;
      end else begin
        grav_cnt_reg <= grav_inc;
      end
    end
  end

  assign ctrl  = ctrl_reg;
  assign level = level_reg;

endmodule

// File: tb/tb_tetris_input_sched.sv
// Directed bench for tetris_input_sched: expected commands are queued with their issue cycle
// when stimulus is applied and matched against every non-NONE ctrl pulse.
module tb_tetris_input_sched;
  import tetris_pkg::*;

  localparam logic [6:0] B_HOLD  = 7'h01;
  localparam logic [6:0] B_DROP  = 7'h02;
  localparam logic [6:0] B_ROT   = 7'h04;
  localparam logic [6:0] B_LEFT  = 7'h10;
  localparam logic [6:0] B_RIGHT = 7'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_left, btn_right, btn_rot, btn_rot_rev, btn_down, btn_drop, btn_hold;
  logic [15:0] score;
  logic        auto_mode;
  state_type   dir_state;
  state_type   state_sig;
  state_type   mstate = WAIT;
  int          bcnt = 0;
  state_type   ctrl;
  logic [3:0]  level;

  typedef struct {
    state_type cmd;
    int        cyc;
  } exp_t;

  exp_t      sb[$];
  int        cyc = 0;
  int        n_vec = 0;
  int        n_err = 0;
  state_type last_ctrl = NONE;
  int        p;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine stand-in: after consuming a command it is busy and reads WAIT again 4 cycles later.
  always @(posedge clk) begin
    if (!auto_mode) begin
      mstate <= WAIT;
      bcnt   <= 0;
    end else if (mstate == WAIT) begin
      if (ctrl != NONE) begin
        mstate <= CLEAR;
        bcnt   <= 3;
      end
    end else begin
      if (bcnt == 1) mstate <= WAIT;
      bcnt <= bcnt - 1;
    end
  end

  always_comb begin
    state_sig = dir_state;
    if (auto_mode) state_sig = mstate;
  end

  tetris_input_sched #(
    .GRAV_BASE(100),
    .GRAV_STEP(10),
    .DAS(20),
    .ARR(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_rot(btn_rot),
    .btn_rot_rev(btn_rot_rev),
    .btn_down(btn_down),
    .btn_drop(btn_drop),
    .btn_hold(btn_hold),
    .state(state_sig),
    .score(score),
    .ctrl(ctrl),
    .level(level)
  );

  task automatic set_btns(input logic [6:0] v);
    {btn_down, btn_right, btn_left, btn_rot_rev, btn_rot, btn_drop, btn_hold} = v;
  endtask

  task automatic push(input state_type cmd, input int at);
    exp_t e;
    e.cmd = cmd;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (ctrl !== NONE) begin
      n_vec++;
      assert ((sb.size() != 0) === 1'b1) else begin
        n_err++;
        $error("FAIL unexpected_cmd: observed %s at cycle %0d, required no command", ctrl.name(), cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_vec++;
        assert (ctrl === e.cmd) else begin
          n_err++;
          $error("FAIL cmd_value: observed %s required %s (cycle %0d)", ctrl.name(), e.cmd.name(), cyc);
        end
        n_vec++;
        assert (cyc === e.cyc) else begin
          n_err++;
          $error("FAIL cmd_cycle: observed %s at cycle %0d required cycle %0d", ctrl.name(), cyc, e.cyc);
        end
        $display("cycle %0d: ctrl %s (expected %s @%0d)", cyc, ctrl.name(), e.cmd.name(), e.cyc);
      end
      n_vec++;
      assert (last_ctrl === NONE) else begin
        n_err++;
        $error("FAIL one_cycle_wide: observed %s then %s at cycle %0d, required NONE between", last_ctrl.name(), ctrl.name(), cyc);
      end
    end
    last_ctrl = ctrl;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_out();
    end
  endtask

  task automatic check_cmd(input string tag, input state_type obs, input state_type req);
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %s required %s", tag, obs.name(), req.name());
    end
  endtask

  task automatic check_lvl(input string tag, input logic [3:0] obs, input logic [3:0] req);
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
    $display("cycle %0d: %s level %0d (expected %0d)", cyc, tag, obs, req);
  endtask

  task automatic check_empty(input string tag);
    n_vec++;
    assert (sb.size() === 0) else begin
      n_err++;
      $error("FAIL %s: observed %0d commands still outstanding, required 0", tag, sb.size());
    end
    sb.delete();
  endtask

  initial begin
    // Reset with every button held and a nonzero score
    reset = 1'b1;
    auto_mode = 1'b0;
    dir_state = WAIT;
    score = 16'h0050;
    set_btns(7'h7f);
    tick(3);
    check_cmd("reset_ctrl", ctrl, NONE);
    check_lvl("reset_level", level, 4'd0);
    reset = 1'b0;
    score = 16'h0000;
    tick(30);
    check_empty("held_through_reset");
    set_btns(7'h00);
    dir_state = INIT;
    tick(2);

    // Priority: HOLD, ROTATE, LEFT pressed together, engine busy 4 cycles after each
    auto_mode = 1'b1;
    set_btns(B_HOLD | B_ROT | B_LEFT);
    p = cyc + 1;
    push(HOLD, p + 1);
    push(ROTATE, p + 6);
    push(LEFT, p + 11);
    tick(1);
    set_btns(7'h00);
    tick(15);
    check_empty("priority");
    auto_mode = 1'b0;
    dir_state = INIT;
    tick(2);

    // Auto-repeat on btn_right, engine fixed at WAIT
    dir_state = WAIT;
    set_btns(B_RIGHT);
    p = cyc + 1;
    push(RIGHT, p + 1);
    for (int k = 20; k <= 35; k += 5) push(RIGHT, p + k);
    tick(39);
    set_btns(7'h00);
    tick(5);
    check_empty("autorepeat");

    // Gravity at level 3 (period 70), then level 9 (period 10)
    dir_state = INIT;
    score = 16'h0030;
    check_lvl("level_lag", level, 4'd0);
    tick(1);
    check_lvl("level_3", level, 4'd3);
    tick(1);
    dir_state = WAIT;
    p = cyc;
    push(DOWN, p + 70);
    push(DOWN, p + 140);
    tick(150);
    check_empty("gravity_l3");
    dir_state = INIT;
    score = 16'h0100;
    tick(1);
    check_lvl("level_9", level, 4'd9);
    tick(1);
    dir_state = WAIT;
    p = cyc;
    for (int k = 1; k <= 3; k++) push(DOWN, p + 10 * k);
    tick(35);
    check_empty("gravity_l9");

    // Busy engine: DROP pressed during CLEAR is held back until WAIT
    dir_state = INIT;
    score = 16'h0000;
    tick(2);
    dir_state = CLEAR;
    tick(2);
    set_btns(B_DROP);
    tick(1);
    set_btns(7'h00);
    tick(17);
    check_empty("busy_no_issue");
    dir_state = WAIT;
    push(DROP, cyc + 1);
    tick(8);
    check_empty("busy_drop_once");

    // Reset during the ISSUE cycle drops the still-pending DROP
    set_btns(B_HOLD | B_DROP);
    p = cyc + 1;
    push(HOLD, p + 1);
    tick(1);
    set_btns(7'h00);
    tick(1);
    reset = 1'b1;
    tick(2);
    check_cmd("reset_mid_issue_ctrl", ctrl, NONE);
    reset = 1'b0;
    tick(10);
    check_empty("reset_mid_issue");

    // INIT start token, then GEN -> WAIT with no stale ROTATE
    dir_state = INIT;
    set_btns(B_ROT);
    push(DOWN, cyc + 1);
    tick(1);
    set_btns(7'h00);
    tick(1);
    dir_state = GEN;
    tick(2);
    dir_state = WAIT;
    tick(10);
    check_empty("init_token");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
